// File: rtl/parqueo_pkg.sv
// Shared definitions for the parking access gate: state codes, default PIN,
// and the state-to-output decode used by the controller.
package parqueo_pkg;

    typedef enum logic [2:0] {
        ESPERA     = 3'd0,
        PIDE_CLAVE = 3'd1,
        ABIERTA    = 3'd2,
        ALARMA_PIN = 3'd3,
        BLOQUEO    = 3'd4
    } estado_t;

    localparam logic [15:0] CLAVE_POR_DEFECTO = 16'h1234;
    localparam int          ANCHO_CONTADOR    = 4;

    typedef struct packed {
        logic compuerta;
        logic alarma_pin;
        logic alarma_bloqueo;
    } salidas_t;

    localparam salidas_t SALIDAS_REPOSO  = 3'b000;
    localparam salidas_t SALIDAS_ABIERTA = 3'b100;
    localparam salidas_t SALIDAS_PIN     = 3'b010;
    localparam salidas_t SALIDAS_BLOQUEO = 3'b001;

    // Moore decode: each state drives at most one of the three signals.
    function automatic salidas_t decodificar(input estado_t e);
        case (e)
            ABIERTA:    return SALIDAS_ABIERTA;
            ALARMA_PIN: return SALIDAS_PIN;
            BLOQUEO:    return SALIDAS_BLOQUEO;
            default:    return SALIDAS_REPOSO;
        endcase
    endfunction

endpackage

// File: rtl/temporizador_compuerta.sv
// Gate-open timer: counts cycles while enabled and flags the last cycle
// before the gate must auto-close.
module temporizador_compuerta #(
    parameter int TIEMPO_ABIERTA = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic habilitar,
    input  logic limpiar,
    output logic expirado
);

    localparam int ANCHO = (TIEMPO_ABIERTA > 1) ? $clog2(TIEMPO_ABIERTA) : 1;
    localparam logic [ANCHO-1:0] ULTIMO = ANCHO'(TIEMPO_ABIERTA - 1);

    logic [ANCHO-1:0] cuenta;

    // Count while enabled; sit at zero whenever disabled or cleared.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cuenta <= '0;
        end else if (limpiar || !habilitar) begin
            cuenta <= '0;
        end else if (cuenta != ULTIMO) begin
            cuenta <= cuenta + ANCHO'(1);
        end
    end

    assign expirado = habilitar && (cuenta == ULTIMO);

endmodule

// File: rtl/controlador_acceso_parqueo.sv
// Parking access gate controller: Moore FSM sequencing the gate from the
// vehicle sensors and PIN entry, with a wrong-PIN attempt counter and a
// gate-open timeout.
module controlador_acceso_parqueo
    import parqueo_pkg::*;
#(
    parameter logic [15:0] CLAVE_CORRECTA = CLAVE_POR_DEFECTO,
    parameter int          MAX_INTENTOS   = 3,
    parameter int          TIEMPO_ABIERTA = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sensor_llegada_vehiculo,
    input  logic        sensor_ingreso_vehiculo,
    input  logic [15:0] clave_ingresada,
    input  logic        clave_lista,
    output logic        senal_compuerta,
    output logic        senal_alarma_pin,
    output logic        senal_alarma_bloqueo,
    output logic [2:0]  estado
);

    localparam logic [ANCHO_CONTADOR-1:0] LIMITE = ANCHO_CONTADOR'(MAX_INTENTOS);

    estado_t                   state, state_next;
    logic [ANCHO_CONTADOR-1:0] intentos, intentos_next, intentos_inc;
    logic                      clave_ok;
    logic                      clave_mala;
    logic                      expirado;
    logic                      limpiar_timer;
    salidas_t                  salidas;

    assign clave_ok     = clave_lista && (clave_ingresada == CLAVE_CORRECTA);
    assign clave_mala   = clave_lista && (clave_ingresada != CLAVE_CORRECTA);
    assign intentos_inc = (intentos == '1) ? intentos : intentos + ANCHO_CONTADOR'(1);

    // Clear the timer on every ABIERTA boundary so it reads zero on entry
    // and stays at zero while the gate is closed.
    assign limpiar_timer = (state == ABIERTA) != (state_next == ABIERTA);

    temporizador_compuerta #(
        .TIEMPO_ABIERTA(TIEMPO_ABIERTA)
    ) u_temporizador (
        .clock    (clock),
        .reset    (reset),
        .habilitar(state == ABIERTA),
        .limpiar  (limpiar_timer),
        .expirado (expirado)
    );

    // State register and attempt counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ESPERA;
            intentos <= '0;
        end else begin
            state    <= state_next;
            intentos <= intentos_next;
        end
    end

    // Next-state and next-counter logic.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next    = state;
        intentos_next = intentos;
        case (state)
            ESPERA: begin
                if (sensor_llegada_vehiculo) state_next = PIDE_CLAVE;
            end
            PIDE_CLAVE: begin
                if (clave_ok) begin
                    state_next    = ABIERTA;
                    intentos_next = '0;
                end else if (clave_mala) begin
                    intentos_next = intentos_inc;
                    if (intentos_inc == LIMITE) state_next = ALARMA_PIN;
                end else if (!sensor_llegada_vehiculo) begin
                    state_next = ESPERA;
                end
            end
            ABIERTA: begin
                if (sensor_llegada_vehiculo && sensor_ingreso_vehiculo) begin
                    state_next = BLOQUEO;
                end else if (sensor_ingreso_vehiculo) begin
                    state_next = ESPERA;
                end else if (expirado) begin
                    state_next = ESPERA;
                end
            end
            ALARMA_PIN: begin
                if (clave_ok) begin
                    state_next    = ABIERTA;
                    intentos_next = '0;
                end
            end
            BLOQUEO: begin
                if (clave_ok) begin
                    state_next    = ESPERA;
                    intentos_next = '0;
                end
            end
            default: state_next = ESPERA;
        endcase
    end

    // Outputs decode the state register only.
    assign salidas              = decodificar(state);
    assign senal_compuerta      = salidas.compuerta;
    assign senal_alarma_pin     = salidas.alarma_pin;
    assign senal_alarma_bloqueo = salidas.alarma_bloqueo;
    assign estado               = state;

endmodule

// File: tb/tb_controlador_acceso_parqueo.sv
// Scoreboard bench for the parking access gate controller: the driver pushes
// the expected post-edge state from a reference model, a monitor pops and
// compares after every rising edge.
module tb_controlador_acceso_parqueo;

    localparam logic [15:0] CLAVE  = 16'h1234;
    localparam int          MAXI   = 3;
    localparam int          TIEMPO = 8;

    logic        clock;
    logic        reset;
    logic        sensor_llegada_vehiculo;
    logic        sensor_ingreso_vehiculo;
    logic [15:0] clave_ingresada;
    logic        clave_lista;
    logic        senal_compuerta;
    logic        senal_alarma_pin;
    logic        senal_alarma_bloqueo;
    logic [2:0]  estado;

    controlador_acceso_parqueo #(
        .CLAVE_CORRECTA(CLAVE),
        .MAX_INTENTOS  (MAXI),
        .TIEMPO_ABIERTA(TIEMPO)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .sensor_llegada_vehiculo(sensor_llegada_vehiculo),
        .sensor_ingreso_vehiculo(sensor_ingreso_vehiculo),
        .clave_ingresada        (clave_ingresada),
        .clave_lista            (clave_lista),
        .senal_compuerta        (senal_compuerta),
        .senal_alarma_pin       (senal_alarma_pin),
        .senal_alarma_bloqueo   (senal_alarma_bloqueo),
        .estado                 (estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] st;
        logic       c;
        logic       p;
        logic       b;
    } esperado_t;

    esperado_t q[$];
    int        n_comp = 0;
    int        n_err  = 0;

    // Reference model: state code, wrong-PIN tally, cycles left before auto-close.
    int m_st       = 0;
    int m_intentos = 0;
    int m_restante = 0;

    task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
        n_comp++;
        if (actual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nombre, actual, esperado, $time);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, advance the model,
    // queue what the DUT must show after the next rising edge.
    task automatic ciclo(input logic lleg, input logic ing, input logic [15:0] clave, input logic lista);
        esperado_t e;
        bit        ok;
        bit        mala;
        @(negedge clock);
        sensor_llegada_vehiculo = lleg;
        sensor_ingreso_vehiculo = ing;
        clave_ingresada         = clave;
        clave_lista             = lista;
        ok   = lista && (clave == CLAVE);
        mala = lista && (clave != CLAVE);
        case (m_st)
            0: if (lleg) m_st = 1;
            1: begin
                if (ok) begin
                    m_st = 2; m_intentos = 0; m_restante = TIEMPO;
                end else if (mala) begin
                    if (m_intentos < 15) m_intentos++;
                    if (m_intentos == MAXI) m_st = 3;
                end else if (!lleg) begin
                    m_st = 0;
                end
            end
            2: begin
                m_restante--;
                if (lleg && ing)         m_st = 4;
                else if (ing)            m_st = 0;
                else if (m_restante == 0) m_st = 0;
            end
            3: if (ok) begin m_st = 2; m_intentos = 0; m_restante = TIEMPO; end
            4: if (ok) begin m_st = 0; m_intentos = 0; end
            default: m_st = 0;
        endcase
        e.st = 3'(m_st);
        e.c  = (m_st == 2);
        e.p  = (m_st == 3);
        e.b  = (m_st == 4);
        q.push_back(e);
    endtask

    // Asynchronous reset in the middle of a low clock phase; outputs must clear at once.
    task automatic reset_asincrono();
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("rst_async_estado", 32'(estado), 32'd0);
        check("rst_async_compuerta", 32'(senal_compuerta), 32'd0);
        check("rst_async_pin", 32'(senal_alarma_pin), 32'd0);
        check("rst_async_bloqueo", 32'(senal_alarma_bloqueo), 32'd0);
        m_st = 0; m_intentos = 0; m_restante = 0;
        sensor_llegada_vehiculo = 1'b0;
        sensor_ingreso_vehiculo = 1'b0;
        clave_lista             = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Monitor: after each rising edge, compare the DUT with the oldest expectation.
    always @(posedge clock) begin
        esperado_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("estado", 32'(estado), 32'(e.st));
            check("compuerta", 32'(senal_compuerta), 32'(e.c));
            check("alarma_pin", 32'(senal_alarma_pin), 32'(e.p));
            check("alarma_bloqueo", 32'(senal_alarma_bloqueo), 32'(e.b));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          abiertos;
        logic [15:0] clave_r;
        reset                   = 1'b0;
        sensor_llegada_vehiculo = 1'b0;
        sensor_ingreso_vehiculo = 1'b0;
        clave_ingresada         = 16'h0000;
        clave_lista             = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_estado", 32'(estado), 32'd0);
        check("reset_compuerta", 32'(senal_compuerta), 32'd0);
        check("reset_pin", 32'(senal_alarma_pin), 32'd0);
        check("reset_bloqueo", 32'(senal_alarma_bloqueo), 32'd0);
        reset = 1'b1;

        // Normal entry and passage.
        ciclo(1, 0, 16'h0000, 0);
        ciclo(1, 0, CLAVE, 1);
        ciclo(0, 1, 16'h0000, 0);

        // Three wrong PINs raise the alarm; a fourth changes nothing; correct PIN opens.
        ciclo(1, 0, 16'h0000, 0);
        ciclo(1, 0, 16'h0000, 1);
        ciclo(1, 0, 16'h1111, 1);
        ciclo(1, 0, 16'h2222, 1);
        ciclo(1, 0, 16'h3333, 1);
        ciclo(0, 0, CLAVE, 1);
        ciclo(0, 1, 16'h0000, 0);

        // Tailgating, wrong PIN ignored, correct PIN clears.
        ciclo(1, 0, 16'h0000, 0);
        ciclo(1, 0, CLAVE, 1);
        ciclo(1, 1, 16'h0000, 0);
        ciclo(0, 0, 16'h0000, 1);
        ciclo(0, 0, CLAVE, 1);

        // Auto-close: gate open for exactly TIEMPO cycles.
        ciclo(1, 0, 16'h0000, 0);
        ciclo(1, 0, CLAVE, 1);
        abiertos = 0;
        for (int i = 0; i < 12; i++) begin
            ciclo(0, 0, 16'h0000, 0);
            if (senal_compuerta) abiertos++;
        end
        check("ciclos_abierta", 32'(abiertos), 32'(TIEMPO));

        // Attempt counter survives the vehicle leaving.
        ciclo(1, 0, 16'h0000, 0);
        ciclo(1, 0, 16'h4444, 1);
        ciclo(1, 0, 16'h5555, 1);
        ciclo(0, 0, 16'h0000, 0);
        ciclo(1, 0, 16'h0000, 0);
        ciclo(1, 0, 16'h6666, 1);
        ciclo(1, 0, CLAVE, 1);
        ciclo(0, 1, 16'h0000, 0);

        // Asynchronous reset in ALARMA_PIN and in ABIERTA.
        ciclo(1, 0, 16'h0000, 0);
        ciclo(1, 0, 16'h0001, 1);
        ciclo(1, 0, 16'h0002, 1);
        ciclo(1, 0, 16'h0003, 1);
        reset_asincrono();
        ciclo(1, 0, 16'h0000, 0);
        ciclo(1, 0, CLAVE, 1);
        ciclo(1, 0, 16'h0000, 0);
        reset_asincrono();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if (i % 200 == 150) reset_asincrono();
            clave_r = ($urandom_range(0, 2) == 0) ? CLAVE : 16'($urandom);
            ciclo(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0),
                  clave_r,
                  ($urandom_range(0, 4) == 0));
        end

        @(negedge clock);
        @(negedge clock);
        check("cola_vacia", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_err);
        $finish;
    end

endmodule

// File: doc/controlador_acceso_parqueo.md
Name: controlador_acceso_parqueo

Overview:
Controller for the parking access gate. It sequences the gate from the vehicle sensors and the PIN entry, and raises the wrong-PIN and tailgating alarms. It is the design the parking tester drives: the sensors and `clave_ingresada` come in, and `senal_compuerta`, `senal_alarma_pin` and `senal_alarma_bloqueo` go out. It is a Moore FSM with an attempt counter and a gate-open timeout counter.

Parameters:
- CLAVE_CORRECTA, 16'h1234: valid PIN.
- MAX_INTENTOS, 3: consecutive wrong PINs that raise the PIN alarm (1..15).
- TIEMPO_ABIERTA, 1000: clock cycles the gate stays open with no vehicle passage before it auto-closes (≥2).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- sensor_llegada_vehiculo  input  1  vehicle present at the gate (level).
- sensor_ingreso_vehiculo  input  1  vehicle crossing / past the gate (level).
- clave_ingresada  input  16  PIN value; sampled only when clave_lista=1.
- clave_lista  input  1  one-cycle strobe: PIN entry complete.
- senal_compuerta  output  1  1 = gate open.
- senal_alarma_pin  output  1  wrong-PIN alarm.
- senal_alarma_bloqueo  output  1  tailgating/blocking alarm.
- estado  output  3  current state, for debug and bench.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=ESPERA; attempt counter=0; timer=0.
  - All three signal outputs=0; estado=ESPERA.
  - Reset asserted mid-operation, including with the gate open or an alarm active, clears everything immediately.
- Encoding: ESPERA=0, PIDE_CLAVE=1, ABIERTA=2, ALARMA_PIN=3, BLOQUEO=4. Codes 5-7 are illegal and go to ESPERA on the next edge.
- Outputs are a decode of the state register only (Moore). They change on the same edge that changes state; input-to-output latency is 1 edge.
  - senal_compuerta=1 only in ABIERTA.
  - senal_alarma_pin=1 only in ALARMA_PIN.
  - senal_alarma_bloqueo=1 only in BLOQUEO.
- ESPERA:
  - llegada=1 → PIDE_CLAVE.
  - ingreso, and clave_lista (any PIN), are ignored.
- PIDE_CLAVE, priority order:
  1. clave_lista=1 with a correct PIN → ABIERTA; counter=0; timer=0.
  2. clave_lista=1 with a wrong PIN → counter+1. If the new count equals MAX_INTENTOS → ALARMA_PIN; otherwise stay.
  3. llegada=0 with no strobe (vehicle left) → ESPERA. The counter is kept and is not cleared by the vehicle leaving.
- ALARMA_PIN:
  - A correct PIN → ABIERTA; counter=0; alarm drops on the same edge.
  - Wrong PINs are ignored; the counter saturates at MAX_INTENTOS.
  - Sensors are ignored.
- ABIERTA: the timer increments each cycle. Priority order:
  1. llegada=1 and ingreso=1 in the same cycle (second vehicle behind the first) → BLOQUEO.
  2. ingreso=1 and llegada=0 (vehicle passed) → ESPERA.
  3. timer = TIEMPO_ABIERTA-1 → ESPERA (auto-close).
  - clave_lista is ignored.
- BLOQUEO:
  - Only a correct PIN exits, → ESPERA; counter=0.
  - Wrong PINs do not increment the counter.
  - Sensors are ignored.
- Width rules:
  - Counter is 4 bits and saturating.
  - Timer is $clog2(TIEMPO_ABIERTA) bits. It resets to 0 on every entry to ABIERTA and is held at 0 outside ABIERTA.
- PIN compare is an exact 16-bit equality; no partial match.

Decomposition:
- Shared package `parqueo_pkg`:
  - State encoding localparams.
  - CLAVE_CORRECTA default.
  - Output decode constants reused by the tester and checker.
- One sub-module, `temporizador_compuerta`:
  - Parameter TIEMPO_ABIERTA.
  - Inputs clock, reset, habilitar, limpiar; output expirado.
  - The FSM drives habilitar=(state==ABIERTA) and limpiar on ABIERTA entry.

Test Plan:
- Reset, then llegada=1, then strobe clave=16'h1234 → estado 0→1→2; compuerta=1 on the strobe edge. Then ingreso=1, llegada=0 → compuerta=0, estado=0.
- Three wrong PINs (16'h0000, 16'h1111, 16'h2222) in PIDE_CLAVE → alarma_pin=1 on the third strobe edge. A fourth wrong PIN changes nothing. Then 16'h1234 → alarma_pin=0, compuerta=1 on the same edge.
- In ABIERTA drive llegada=1 and ingreso=1 together → alarma_bloqueo=1, compuerta=0. Wrong PIN → no change. 16'h1234 → alarma_bloqueo=0, estado=0.
- With TIEMPO_ABIERTA=8: open the gate and hold the sensors at 0 → compuerta=1 for exactly 8 cycles, then 0, estado=0.
- Two wrong PINs, vehicle leaves, vehicle returns, one more wrong PIN → alarma_pin=1 (counter retained).
- Assert reset=0 asynchronously, mid-cycle, while in ALARMA_PIN and again in ABIERTA → all outputs 0 before the next clock edge; estado=0.
